// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator. Free-running h/v counters (stage 0)
//   feed a one-register coordinate stage (x, y, addr_vld) and a LEAD+1 deep
//   strobe pipeline (hsync, vsync, de, line_start, frame_start). This lets
//   the coordinates lead the video strobes by LEAD cycles, so a fetch pipeline
//   of that depth lands its data on de.
//
// Ports
//   clk          in   pixel clock
//   rst          in   asynchronous active-high reset
//   en           in   run enable; low clears the raster and flushes pipelines
//   hsync        out  horizontal sync (active level H_POL)
//   vsync        out  vertical sync (active level V_POL)
//   de           out  visible-region strobe
//   line_start   out  pulse at h = 0, aligned with de
//   frame_start  out  pulse at (h, v) = (0, 0), aligned with de
//   addr_vld     out  coordinate valid, LEAD cycles ahead of de
//   x, y         out  active pixel column / line, 0 outside the active region
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BACK   = 88,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FRONT  = 40,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BACK   = 23,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FRONT  = 1,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned LEAD     = 1,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic             addr_vld,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y
);

  localparam int unsigned H_TOTAL   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned H_ACT_BEG = H_SYNC + H_BACK;
  localparam int unsigned H_ACT_END = H_SYNC + H_BACK + H_ACTIVE;
  localparam int unsigned V_ACT_BEG = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_END = V_SYNC + V_BACK + V_ACTIVE;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_OFS  = CNT_W'(H_ACT_BEG);
  localparam logic [CNT_W-1:0] V_OFS  = CNT_W'(V_ACT_BEG);

  // Strobe vector layout: {hsync, vsync, de, line_start, frame_start}
  localparam logic [4:0] V_IDLE = {~H_POL, ~V_POL, 3'b000};

  logic [CNT_W-1:0] h, v;
  logic [31:0]      hh, vv;
  logic             h_act, v_act, act;
  logic             hs_act, vs_act;
  logic [4:0]       s0;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic [4:0]       vpipe [0:LEAD];

  // Stage 0: raster counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (!en) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + ONE;
    end else begin
      h <= h + ONE;
    end
  end

  // Region decode on the current counter position. Comparisons are done in
  // 32 bits so an active region ending exactly at 2^CNT_W cannot alias to 0.
  always_comb begin
    hh     = 32'(h);
    vv     = 32'(v);
    h_act  = (hh >= H_ACT_BEG) && (hh < H_ACT_END);
    v_act  = (vv >= V_ACT_BEG) && (vv < V_ACT_END);
    act    = h_act && v_act;
    hs_act = hh < H_SYNC;
    vs_act = vv < V_SYNC;
    s0     = {hs_act ? H_POL : ~H_POL,
              vs_act ? V_POL : ~V_POL,
              act,
              h == '0,
              (h == '0) && (v == '0)};
    x_nxt  = act ? h - H_OFS : '0;
    y_nxt  = act ? v - V_OFS : '0;
  end

  // Stage A: coordinates, one register after the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_vld <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else if (!en) begin
      addr_vld <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else begin
      addr_vld <= act;
      x        <= x_nxt;
      y        <= y_nxt;
    end
  end

  // Stage V: strobes delayed LEAD+1 registers after the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= LEAD; i++) vpipe[i] <= V_IDLE;
    end else if (!en) begin
      for (int unsigned i = 0; i <= LEAD; i++) vpipe[i] <= V_IDLE;
    end else begin
      vpipe[0] <= s0;
      for (int unsigned i = 1; i <= LEAD; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  assign {hsync, vsync, de, line_start, frame_start} = vpipe[LEAD];

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA output path. Produces horizontal and vertical sync, data-enable, pixel coordinates and line/frame markers for any mode set by porch/sync/active parameters. Pixel coordinates can be issued a programmable number of cycles ahead of the video strobes, so a frame-buffer or ROM read pipeline lands exactly on `de`. It sits between the pixel-clock domain's reset/clock source and the pixel-fetch/colour-output logic.

## Interface
- `H_SYNC`, 128: hsync width, pixel clocks
- `H_BACK`, 88: horizontal back porch
- `H_ACTIVE`, 800: visible pixels per line
- `H_FRONT`, 40: horizontal front porch
- `V_SYNC`, 4: vsync width, lines
- `V_BACK`, 23: vertical back porch
- `V_ACTIVE`, 600: visible lines
- `V_FRONT`, 1: vertical front porch
- `H_POL`, 0: hsync active level (0 = active-low)
- `V_POL`, 0: vsync active level
- `LEAD`, 1: cycles by which `x`/`y`/`addr_vld` precede `de`; legal range 0..4
- `CNT_W`, 12: counter/coordinate width; H_TOTAL and V_TOTAL must be ≤ 2^CNT_W

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  run enable; low = synchronous clear of the raster
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `de`  out  1  visible-region strobe
- `line_start`  out  1  one-cycle pulse at h = 0 of every line, aligned with `de`
- `frame_start`  out  1  one-cycle pulse at (h, v) = (0, 0), aligned with `de`
- `addr_vld`  out  1  coordinate-valid strobe, LEAD cycles ahead of `de`
- `x`  out  CNT_W  active pixel column 0..H_ACTIVE-1, else 0
- `y`  out  CNT_W  active line 0..V_ACTIVE-1, else 0

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL likewise. Region order within each period: sync, back porch, active, front porch.
- `h` counts 0..H_TOTAL-1 and wraps to 0.
- `v` advances only on the h wrap and counts 0..V_TOTAL-1. On the simultaneous h and v wrap, both become 0 on the same edge.
- Sync is active for h < H_SYNC and v < V_SYNC. Output level = POL when active, ~POL otherwise.
- Active region: H_SYNC+H_BACK ≤ h < H_SYNC+H_BACK+H_ACTIVE, and the same form vertically.
- `x` = h − (H_SYNC+H_BACK) and `y` = v − (V_SYNC+V_BACK) inside the active region; both are 0 outside it. Subtraction is in CNT_W bits, with no wrap inside the active region.
- Stage 0 is the counters. Stage A (one register) holds `x`, `y`, `addr_vld`. Stage V holds `hsync`, `vsync`, `de`, `line_start`, `frame_start`, and is stage 0 delayed by LEAD+1 registers. All outputs come from flops; no output is combinational.
- `en` = 0:
  - h and v are cleared to 0 and held.
  - The delay pipeline is flushed to idle values.
  - All outputs go to their reset values one edge later.
- `en` rising: counting restarts at (0, 0), so a fresh frame always begins with `frame_start`.
- `rst` asserted at any time, including mid-line: all state clears immediately.

## Timing
- Reset values:
  - `hsync` = ~H_POL, `vsync` = ~V_POL.
  - `de`, `line_start`, `frame_start`, `addr_vld`, `x`, `y` = 0.
  - h = v = 0.
- While held at h = v = 0, a counter position is presented to stage A on the next edge. For the first position after reset release with `en` = 1:
  - Stage A shows position (0, 0) after edge 1.
  - Stage V shows position (0, 0) after edge 1+LEAD, so `frame_start` first asserts then.
- General rule: for any position, `addr_vld`/`x`/`y` appear exactly LEAD cycles before the matching `de`/syncs. LEAD = 0 aligns them.
- Per line:
  - `de` is high for exactly H_ACTIVE consecutive cycles.
  - `line_start` period is H_TOTAL cycles.
  - `hsync` is active for H_SYNC cycles.
- Per frame:
  - `frame_start` period is H_TOTAL·V_TOTAL cycles.
  - `vsync` is active for V_SYNC·H_TOTAL cycles, with edges coincident with `line_start` cycles.
- Within a line, `x` increments by 1 per cycle from 0 to H_ACTIVE−1. `y` is constant within a line.

## Test plan
- Default parameters, LEAD = 1, `en` = 1:
  - `frame_start` period = 663168 cycles.
  - `hsync` low 128 of every 1056 cycles.
  - `de` high 800 cycles/line for 600 lines/frame.
  - `vsync` low 4224 cycles.
- Small mode (H 2/1/4/1, V 1/1/3/1, LEAD = 0, H_POL = V_POL = 1), checked cycle by cycle from reset release:
  - `hsync` high at h 0..1, `de` at h 3..6, `x` = 0,1,2,3.
  - `vsync` high during line 0.
  - `y` = 0..2 on lines 2..4.
  - Frame = 48 cycles.
- LEAD = 3: `addr_vld` rises with `x` = 0 exactly 3 cycles before `de` rises, and falls 3 cycles before `de` falls, on every active line.
- `en` dropped mid-active-line:
  - One edge later all outputs are at reset values.
  - On `en` reassert, `frame_start` occurs LEAD+1 edges later and the full frame sequence repeats.
- `rst` pulsed asynchronously mid-frame (between edges): outputs take reset values immediately, and the sequence restarts exactly as after power-on.
- Wrap boundary: at h = H_TOTAL−1, v = V_TOTAL−1, the next position is (0, 0). Both `line_start` and `frame_start` pulse in the same cycle, and there is no extra or missing line.
